// File: rtl/period_meter.sv
// period_meter: measures the rising-to-rising period of an asynchronous slow input in clk cycles.
// Optional macro PERIOD_METER_DUTY_EN adds the high_time output (rise-to-fall duration).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | counter held at 0; waiting for a rise to arm the meter
// MEASURE | counting clk cycles since the last rise; next rise publishes
module period_meter #(
    parameter int WIDTH      = 16,
    parameter int MIN_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             timeout,
`ifdef PERIOD_METER_DUTY_EN
    output logic [WIDTH-1:0] high_time,
`endif
    output logic             glitch
);

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH:0]   MIN_M   = (WIDTH+1)'(MIN_PERIOD);
    localparam logic [WIDTH:0]   ONE_M   = (WIDTH+1)'(1);

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             glitch_q, glitch_d;
    logic             rise;
    logic [WIDTH:0]   m;

`ifdef PERIOD_METER_DUTY_EN
    logic [WIDTH-1:0] ht_lat_q, ht_lat_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;
    logic             fall_seen_q, fall_seen_d;
    logic             fall;
`endif

    assign rise = s2_q & ~s3_q;
    // One extra bit so a rise on the terminal count shows up as 2^WIDTH.
    assign m    = {1'b0, cnt_q} + ONE_M;
`ifdef PERIOD_METER_DUTY_EN
    assign fall = ~s2_q & s3_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        timeout_d = timeout_q;
        valid_d   = 1'b0;
        glitch_d  = 1'b0;
`ifdef PERIOD_METER_DUTY_EN
        ht_lat_d    = ht_lat_q;
        high_time_d = high_time_q;
        fall_seen_d = fall_seen_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = ST_MEASURE;
`ifdef PERIOD_METER_DUTY_EN
                    fall_seen_d = 1'b0;
`endif
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    cnt_d = '0;
`ifdef PERIOD_METER_DUTY_EN
                    fall_seen_d = 1'b0;
`endif
                    if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                    end else if (m >= MIN_M) begin
                        period_d  = m[WIDTH-1:0];
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
`ifdef PERIOD_METER_DUTY_EN
                        high_time_d = fall_seen_q ? ht_lat_q : m[WIDTH-1:0];
`endif
                    end else begin
                        glitch_d = 1'b1;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`ifdef PERIOD_METER_DUTY_EN
                    if (fall) begin
                        ht_lat_d    = m[WIDTH-1:0];
                        fall_seen_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            glitch_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= sig_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            glitch_q  <= glitch_d;
        end
    end

`ifdef PERIOD_METER_DUTY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ht_lat_q    <= '0;
            high_time_q <= '0;
            fall_seen_q <= 1'b0;
        end else begin
            ht_lat_q    <= ht_lat_d;
            high_time_q <= high_time_d;
            fall_seen_q <= fall_seen_d;
        end
    end

    assign high_time = high_time_q;
`endif

    assign period  = period_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;
    assign glitch  = glitch_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed self-checking bench for period_meter (WIDTH=6, MIN_PERIOD=4).
// Covers high_time too when PERIOD_METER_DUTY_EN is defined.
module tb_period_meter;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rstn;
    logic         sig_in;
    logic [W-1:0] period;
    logic         valid;
    logic         timeout;
    logic         glitch;
`ifdef PERIOD_METER_DUTY_EN
    logic [W-1:0] high_time;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int nvalid;
        int nglitch;
        int first_valid;
        int last_per;
        int min_per;
        int max_per;
        int min_gap;
        int max_gap;
        int tmo_first;
    } wave_res_t;

    period_meter #(.WIDTH(W), .MIN_PERIOD(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .sig_in  (sig_in),
        .period  (period),
        .valid   (valid),
        .timeout (timeout),
`ifdef PERIOD_METER_DUTY_EN
        .high_time (high_time),
`endif
        .glitch  (glitch)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a square wave starting with a rising edge at index 0 and
    // records what the meter reported; observation i is taken after edge i.
    task automatic run_wave(input int hi, input int lo, input int cycles, output wave_res_t r);
        int last_v;
        r.nvalid = 0; r.nglitch = 0; r.first_valid = -1; r.last_per = -1;
        r.min_per = 1 << 30; r.max_per = 0; r.min_gap = 1 << 30; r.max_gap = 0;
        r.tmo_first = -1;
        last_v = -1;
        for (int i = 0; i < cycles; i++) begin
            sig_in = ((i % (hi + lo)) < hi);
            tick();
            if (valid === 1'b1) begin
                if (r.first_valid < 0) r.first_valid = i;
                if (last_v >= 0) begin
                    if (i - last_v < r.min_gap) r.min_gap = i - last_v;
                    if (i - last_v > r.max_gap) r.max_gap = i - last_v;
                end
                last_v = i;
                r.nvalid++;
                r.last_per = int'(period);
                if (int'(period) < r.min_per) r.min_per = int'(period);
                if (int'(period) > r.max_per) r.max_per = int'(period);
            end
            if (glitch === 1'b1) r.nglitch++;
            if (timeout === 1'b1 && r.tmo_first < 0) r.tmo_first = i;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        sig_in = 1'b0;
        #2 rstn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sig_in = i[1];
            tick();
            n_tests++;
            if ({period, valid, timeout, glitch} !== '0) begin
                $display("FAIL reset_outputs: cycle %0d got period=%0d valid=%b timeout=%b glitch=%b want all 0",
                         i, period, valid, timeout, glitch);
                n_fail++;
            end
        end
        sig_in = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_steady();
        wave_res_t r;
        run_wave(5, 5, 70, r);
        n_tests++;
        if (r.first_valid !== 12) begin
            $display("FAIL steady_first_valid: got %0d want 12", r.first_valid); n_fail++;
        end
        n_tests++;
        if (r.nvalid !== 6) begin
            $display("FAIL steady_nvalid: got %0d want 6", r.nvalid); n_fail++;
        end
        n_tests++;
        if (r.min_per !== 10 || r.max_per !== 10) begin
            $display("FAIL steady_period: got min %0d max %0d want 10", r.min_per, r.max_per); n_fail++;
        end
        n_tests++;
        if (r.min_gap !== 10 || r.max_gap !== 10) begin
            $display("FAIL steady_gap: got min %0d max %0d want 10", r.min_gap, r.max_gap); n_fail++;
        end
        n_tests++;
        if (r.nglitch !== 0) begin
            $display("FAIL steady_glitch: got %0d want 0", r.nglitch); n_fail++;
        end
    endtask

    task automatic test_rate_change();
        wave_res_t r;
        run_wave(12, 12, 96, r);
        n_tests++;
        if (r.nvalid !== 4) begin
            $display("FAIL rate_nvalid: got %0d want 4", r.nvalid); n_fail++;
        end
        n_tests++;
        if (r.last_per !== 24 || r.min_per !== 10 || r.max_per !== 24) begin
            $display("FAIL rate_period: got last %0d min %0d max %0d want 24/10/24",
                     r.last_per, r.min_per, r.max_per); n_fail++;
        end
        n_tests++;
        if (r.min_gap !== 24 || r.max_gap !== 24) begin
            $display("FAIL rate_gap: got min %0d max %0d want 24", r.min_gap, r.max_gap); n_fail++;
        end
        n_tests++;
        if (r.nglitch !== 0) begin
            $display("FAIL rate_glitch: got %0d want 0", r.nglitch); n_fail++;
        end
    endtask

    task automatic test_glitch();
        wave_res_t r;
        logic [11:0] pat;
        run_wave(5, 5, 40, r);
        n_tests++;
        if (r.nvalid !== 4 || r.last_per !== 10) begin
            $display("FAIL glitch_pre: got nvalid %0d last %0d want 4/10", r.nvalid, r.last_per); n_fail++;
        end
        pat = 12'b0000_0000_0101;
        for (int i = 0; i < 12; i++) begin
            sig_in = pat[i];
            tick();
            n_tests++;
            if (valid !== (i == 2) || glitch !== (i == 4)) begin
                $display("FAIL glitch_strobes: cycle %0d got valid=%b glitch=%b want %b/%b",
                         i, valid, glitch, (i == 2), (i == 4)); n_fail++;
            end
            if (i == 4) begin
                n_tests++;
                if (period !== 6'd10) begin
                    $display("FAIL glitch_period_hold: got %0d want 10", period); n_fail++;
                end
            end
        end
    endtask

    task automatic test_timeout();
        wave_res_t r;
        int tmo_k;
        run_wave(5, 5, 20, r);
        n_tests++;
        if (r.nvalid !== 2 || r.min_per !== 10 || r.max_per !== 10 || r.nglitch !== 0) begin
            $display("FAIL post_glitch_wave: got nvalid %0d per %0d..%0d glitch %0d want 2 10..10 0",
                     r.nvalid, r.min_per, r.max_per, r.nglitch); n_fail++;
        end
        sig_in = 1'b0;
        tmo_k = -1;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (timeout === 1'b1 && tmo_k < 0) tmo_k = k;
        end
        n_tests++;
        if (tmo_k !== 56) begin
            $display("FAIL timeout_cycle: got %0d want 56", tmo_k); n_fail++;
        end
        n_tests++;
        if (period !== 6'd10) begin
            $display("FAIL timeout_period_hold: got %0d want 10", period); n_fail++;
        end
        run_wave(4, 4, 32, r);
        n_tests++;
        if (r.first_valid !== 10 || r.nvalid !== 3 || r.last_per !== 8) begin
            $display("FAIL restart: got first %0d nvalid %0d last %0d want 10/3/8",
                     r.first_valid, r.nvalid, r.last_per); n_fail++;
        end
        n_tests++;
        if (timeout !== 1'b0) begin
            $display("FAIL restart_timeout_clear: got %b want 0", timeout); n_fail++;
        end
    endtask

    task automatic test_rise_at_max();
        wave_res_t r;
        sig_in = 1'b0;
        for (int k = 0; k < 56; k++) tick();
        n_tests++;
        if (timeout !== 1'b0) begin
            $display("FAIL max_pre_timeout: got %b want 0", timeout); n_fail++;
        end
        run_wave(4, 4, 16, r);
        n_tests++;
        if (r.tmo_first !== 2) begin
            $display("FAIL max_timeout_cycle: got %0d want 2", r.tmo_first); n_fail++;
        end
        n_tests++;
        if (r.first_valid !== 10 || r.nvalid !== 1 || r.last_per !== 8) begin
            $display("FAIL max_stays_measure: got first %0d nvalid %0d last %0d want 10/1/8",
                     r.first_valid, r.nvalid, r.last_per); n_fail++;
        end
        n_tests++;
        if (timeout !== 1'b0) begin
            $display("FAIL max_timeout_clear: got %b want 0", timeout); n_fail++;
        end
    endtask

    task automatic test_async_reset();
        wave_res_t r;
        run_wave(5, 5, 15, r);
        sig_in = 1'b0;
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        n_tests++;
        if ({period, valid, timeout, glitch} !== '0) begin
            $display("FAIL async_reset: got period=%0d valid=%b timeout=%b glitch=%b want all 0",
                     period, valid, timeout, glitch); n_fail++;
        end
        tick();
        rstn = 1'b1;
        run_wave(5, 5, 30, r);
        n_tests++;
        if (r.first_valid !== 12 || r.nvalid !== 2 || r.last_per !== 10) begin
            $display("FAIL async_rearm: got first %0d nvalid %0d last %0d want 12/2/10",
                     r.first_valid, r.nvalid, r.last_per); n_fail++;
        end
    endtask

`ifdef PERIOD_METER_DUTY_EN
    task automatic test_duty();
        wave_res_t r;
        run_wave(3, 9, 48, r);
        n_tests++;
        if (r.nvalid !== 4 || r.last_per !== 12 || high_time !== 6'd3) begin
            $display("FAIL duty_high_time: got nvalid %0d period %0d high_time %0d want 4/12/3",
                     r.nvalid, r.last_per, high_time); n_fail++;
        end
        sig_in = 1'b1;
        for (int k = 0; k < 100; k++) tick();
        n_tests++;
        if (timeout !== 1'b1 || high_time !== 6'd3 || period !== 6'd12) begin
            $display("FAIL duty_stuck_high: got timeout %b high_time %0d period %0d want 1/3/12",
                     timeout, high_time, period); n_fail++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_steady();
        test_rate_change();
        test_glitch();
        test_timeout();
        test_rise_at_max();
        test_async_reset();
`ifdef PERIOD_METER_DUTY_EN
        test_duty();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
